keypad_scan: RTL and testbench

Matrix-keypad scanner for the HMS clock board. It is the input-side counterpart of the multiplexed LED display driver. The display drives segment data out one digit at a time; this block drives a 4×4 keypad one column at a time, samples the row lines, and turns each stable keypress into a 4-bit key code with press and release event pulses. It sits between the board keypad pins and the clock controller, alongside or in place of the debounced push-switches.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/scan_tick.sv | 31 +++
 rtl/keypad_scan.sv | 179 +++++++++++++++++
 tb/tb_keypad_scan.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Snapshot bit index is col*4 + row; key codes are row*4 + col.
package keypad_pkg;

  localparam int unsigned N_COL  = 4;
  localparam int unsigned N_ROW  = 4;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned SNAP_W = N_COL * N_ROW;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_KEY,
    CLS_MULTI
  } cls_e;

  typedef enum logic {
    ST_IDLE,
    ST_PRESSED
  } state_e;

  // Snapshot is stored column-major, key codes are row-major.
  function automatic logic [KEY_W-1:0] bit_to_key(input logic [3:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running step counter: one-clk step pulse every SCAN_DIV cycles.
module scan_tick #(
  parameter int unsigned SCAN_DIV = 5000
) (
  input  logic clk,
  input  logic rst_n,
  output logic step
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign step = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (step) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sampling, scan classification,
// debounce and press/release event generation.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 5000,
  parameter int unsigned DEB_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [N_COL-1:0] o_col,
  input  logic [N_ROW-1:0] i_row,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  output logic             o_key_held,
  output logic             o_key_release
);

  localparam logic [3:0] DEB = 4'(DEB_SCANS);

  logic step;

  scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step)
  );

  // Rows idle high (pull-ups), so the synchronizer resets to all ones.
  logic [N_ROW-1:0] row_meta_q, row_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= i_row;
      row_sync_q <= row_meta_q;
    end
  end

  logic [1:0]        col_q, col_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic              scan_end;

  assign scan_end = step && (col_q == 2'd3);
  assign o_col    = ~(4'b0001 << col_q);

  always_comb begin
    snap_d = snap_q;
    col_d  = col_q;
    if (step) begin
      snap_d[{col_q, 2'b00} +: 4] = ~row_sync_q;
      col_d                       = col_q + 2'd1;
    end
  end

  // Classify the snapshot including the column sampled on this step edge.
  logic [1:0]       ones;
  logic [3:0]       hit_idx;
  cls_e             cls;
  logic [KEY_W-1:0] scan_key;

  always_comb begin
    ones    = 2'd0;
    hit_idx = 4'd0;
    for (int i = 0; i < SNAP_W; i++) begin
      if (snap_d[i]) begin
        if (ones != 2'd2) begin
          ones = ones + 2'd1;
        end
        hit_idx = 4'(i);
      end
    end
    unique case (ones)
      2'd0:    cls = CLS_NONE;
      2'd1:    cls = CLS_KEY;
      default: cls = CLS_MULTI;
    endcase
    scan_key = bit_to_key(hit_idx);
  end

  cls_e             prev_cls_q, prev_cls_d;
  logic [KEY_W-1:0] prev_key_q, prev_key_d;
  logic [3:0]       stable_q, stable_d;
  logic             same_cls;
  logic             reached;

  always_comb begin
    same_cls   = (cls == prev_cls_q) && ((cls != CLS_KEY) || (scan_key == prev_key_q));
    prev_cls_d = prev_cls_q;
    prev_key_d = prev_key_q;
    stable_d   = stable_q;
    reached    = 1'b0;
    if (scan_end) begin
      prev_cls_d = cls;
      prev_key_d = scan_key;
      if (!same_cls) begin
        stable_d = 4'd1;
      end else if (stable_q != DEB) begin
        stable_d = stable_q + 4'd1;
      end
      // A saturated run must not re-fire; a fresh run always may.
      reached = (stable_d == DEB) && (!same_cls || (stable_q != DEB));
    end
  end

  state_e           state_q, state_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             release_q, release_d;
  logic             held_q, held_d;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    release_d = 1'b0;
    held_d    = held_q;
    unique case (state_q)
      ST_IDLE: begin
        if (reached && (cls == CLS_KEY)) begin
          state_d = ST_PRESSED;
          code_d  = scan_key;
          valid_d = 1'b1;
          held_d  = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (reached && (cls == CLS_NONE)) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else if (reached && (cls == CLS_KEY) && (scan_key != code_q)) begin
          code_d  = scan_key;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= 2'd0;
      snap_q     <= '0;
      prev_cls_q <= CLS_NONE;
      prev_key_q <= '0;
      stable_q   <= 4'd0;
      state_q    <= ST_IDLE;
      code_q     <= '0;
      valid_q    <= 1'b0;
      release_q  <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      snap_q     <= snap_d;
      prev_cls_q <= prev_cls_d;
      prev_key_q <= prev_key_d;
      stable_q   <= stable_d;
      state_q    <= state_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      release_q  <= release_d;
      held_q     <= held_d;
    end
  end

  assign o_key_code    = code_q;
  assign o_key_valid   = valid_q;
  assign o_key_held    = held_q;
  assign o_key_release = release_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a resistive 4x4 matrix model and an event scoreboard.
module tb_keypad_scan;

  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned DEB_SCANS = 3;
  localparam int unsigned SCAN      = 4 * SCAN_DIV;
  localparam int unsigned LAT       = DEB_SCANS * SCAN;

  logic        clk;
  logic        rst_n;
  logic [3:0]  o_col;
  logic [3:0]  i_row;
  logic [3:0]  o_key_code;
  logic        o_key_valid;
  logic        o_key_held;
  logic        o_key_release;
  logic [15:0] keys;  // indexed by key code row*4 + col

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_SCANS(DEB_SCANS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_col        (o_col),
    .i_row        (i_row),
    .o_key_code   (o_key_code),
    .o_key_valid  (o_key_valid),
    .o_key_held   (o_key_held),
    .o_key_release(o_key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    i_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!o_col[c] && keys[r*4+c]) begin
          i_row[r] = 1'b0;
        end
      end
    end
  end

  // Bench-owned cycle count since reset release; scans end at multiples of SCAN.
  logic [31:0] cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end

  typedef struct packed {
    logic        rel;
    logic [3:0]  code;
    logic        held;
    logic [31:0] cyc;
  } evt_t;

  evt_t obs_mem [64];
  int   obs_wr = 0;
  int   obs_rd = 0;
  evt_t exp_q[$];

  always @(negedge clk) begin
    if ((o_key_valid || o_key_release) && obs_wr < 64) begin
      obs_mem[obs_wr] <= '{rel: o_key_release, code: o_key_code, held: o_key_held, cyc: cyc};
      obs_wr          <= obs_wr + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input logic rel, input logic [3:0] code, input logic [31:0] at);
    exp_q.push_back('{rel: rel, code: code, held: ~rel, cyc: at});
  endtask

  task automatic check_events(input string tag);
    evt_t e, o;
    #1;
    chk({tag, "_evt_count"}, 32'(obs_wr - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      e = exp_q.pop_front();
      o = obs_mem[obs_rd];
      obs_rd++;
      chk({tag, "_evt_kind"}, 32'(o.rel), 32'(e.rel));
      chk({tag, "_evt_code"}, 32'(o.code), 32'(e.code));
      chk({tag, "_evt_held"}, 32'(o.held), 32'(e.held));
      chk({tag, "_evt_cycle"}, o.cyc, e.cyc);
    end
    exp_q.delete();
    obs_rd = obs_wr;
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_col;
    keys  = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(o_col), 32'h0000_000E);
    chk("rst_outs", {26'd0, o_key_code, o_key_valid, o_key_held},
        32'(o_key_release));
    chk("rst_release", 32'(o_key_release), 32'd0);
    rst_n = 1'b1;

    // Column rotation: single low bit, advancing every SCAN_DIV clocks.
    for (int i = 0; i < int'(SCAN); i++) begin
      exp_col = ~(4'b0001 << (i / SCAN_DIV));
      chk("col_rotate", 32'(o_col), 32'(exp_col));
      @(negedge clk);
    end
    chk("idle_quiet", {29'd0, o_key_valid, o_key_held, o_key_release}, 32'd0);
    check_events("idle");

    // Single press: key (row 2, col 1) = code 9.
    keys[9] = 1'b1;
    expect_evt(1'b0, 4'd9, cyc + LAT);
    run_scans(10);
    chk("press_held", 32'(o_key_held), 32'd1);
    keys = 16'h0000;
    expect_evt(1'b1, 4'd9, cyc + LAT);
    run_scans(4);
    check_events("single");
    chk("code_kept", 32'(o_key_code), 32'd9);

    // Glitch shorter than the debounce run.
    keys[5] = 1'b1;
    run_scans(DEB_SCANS - 1);
    keys = 16'h0000;
    run_scans(4);
    check_events("glitch");

    // Ghosting: two keys never qualify; dropping one leaves a clean press.
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    run_scans(6);
    chk("ghost_held", 32'(o_key_held), 32'd0);
    check_events("ghost");
    keys[15] = 1'b0;
    expect_evt(1'b0, 4'd0, cyc + LAT);
    run_scans(4);
    keys = 16'h0000;
    expect_evt(1'b1, 4'd0, cyc + LAT);
    run_scans(4);
    check_events("ghost_drop");

    // Roll-over from key 3 (row 0, col 3) to key 12 (row 3, col 0) without a gap.
    keys[3] = 1'b1;
    expect_evt(1'b0, 4'd3, cyc + LAT);
    run_scans(4);
    keys = 16'h1000;
    expect_evt(1'b0, 4'd12, cyc + LAT);
    run_scans(4);
    chk("roll_held", 32'(o_key_held), 32'd1);
    chk("roll_code", 32'(o_key_code), 32'd12);
    keys = 16'h0000;
    expect_evt(1'b1, 4'd12, cyc + LAT);
    run_scans(4);
    check_events("rollover");

    // Asynchronous reset while key 7 is held, mid-scan.
    keys[7] = 1'b1;
    expect_evt(1'b0, 4'd7, cyc + LAT);
    run_scans(5);
    repeat (13) @(negedge clk);
    check_events("hold7");
    rst_n = 1'b0;
    #1;
    chk("midrst_col", 32'(o_col), 32'h0000_000E);
    chk("midrst_code", 32'(o_key_code), 32'd0);
    chk("midrst_flags", {29'd0, o_key_valid, o_key_held, o_key_release}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_evt(1'b0, 4'd7, cyc + LAT);
    run_scans(4);
    check_events("after_rst");
    keys = 16'h0000;
    expect_evt(1'b1, 4'd7, cyc + LAT);
    run_scans(4);
    check_events("rel7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
